// File: rtl/alu_share_arbiter.sv
// Shares one EX-stage ALU between two requesters; response at accept+2, stalls in RESP until consumer takes it.
// Optional macro ALU_ARB_OPCHECK_EN adds o_resp_err and bypasses the ALU for illegal opcodes.
module alu_share_arbiter #(
  parameter int DATA_W      = 32,
  parameter int OP_W        = 5,
  parameter int PRIO0_FIXED = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_r0_valid,
  output logic              o_r0_ready,
  input  logic [OP_W-1:0]   i_r0_op,
  input  logic [DATA_W-1:0] i_r0_a,
  input  logic [DATA_W-1:0] i_r0_b,
  input  logic              i_r1_valid,
  output logic              o_r1_ready,
  input  logic [OP_W-1:0]   i_r1_op,
  input  logic [DATA_W-1:0] i_r1_a,
  input  logic [DATA_W-1:0] i_r1_b,
  output logic [OP_W-1:0]   o_alu_op,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  input  logic [DATA_W-1:0] i_alu_res,
  output logic              o_resp_valid,
  output logic              o_resp_id,
  output logic [DATA_W-1:0] o_resp_data,
  input  logic              i_resp_ready,
`ifdef ALU_ARB_OPCHECK_EN
  output logic              o_resp_err,
`endif
  output logic              o_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        r_state;
  logic              r_rr_ptr;
  logic [OP_W-1:0]   r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_id;
  logic              r_resp_valid;
  logic              r_resp_id;
  logic [DATA_W-1:0] r_resp_data;

  logic              w_idle;
  logic              w_fixed;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_acc;
  logic              w_acc_id;
  logic [OP_W-1:0]   w_acc_op;
  logic [DATA_W-1:0] w_acc_a;
  logic [DATA_W-1:0] w_acc_b;

  assign w_idle  = (r_state == S_IDLE);
  assign w_fixed = (PRIO0_FIXED != 0);

  // r0 wins unless r1 also asks and the round-robin pointer favours r1
  assign w_gnt0 = i_r0_valid & (~i_r1_valid | w_fixed | ~r_rr_ptr);
  assign w_gnt1 = i_r1_valid & ~w_gnt0;

  assign o_r0_ready = w_idle & w_gnt0 & ~i_rst;
  assign o_r1_ready = w_idle & w_gnt1 & ~i_rst;

  assign w_acc    = o_r0_ready | o_r1_ready;
  assign w_acc_id = o_r1_ready;
  assign w_acc_op = w_acc_id ? i_r1_op : i_r0_op;
  assign w_acc_a  = w_acc_id ? i_r1_a  : i_r0_a;
  assign w_acc_b  = w_acc_id ? i_r1_b  : i_r0_b;

  assign o_alu_op = (r_state == S_EXEC) ? r_op : '0;
  assign o_alu_a  = (r_state == S_EXEC) ? r_a  : '0;
  assign o_alu_b  = (r_state == S_EXEC) ? r_b  : '0;

  assign o_resp_valid = r_resp_valid;
  assign o_resp_id    = r_resp_id;
  assign o_resp_data  = r_resp_data;
  assign o_busy       = ~w_idle;

`ifdef ALU_ARB_OPCHECK_EN
  logic r_resp_err;
  logic w_acc_legal;

  function automatic logic f_op_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_W'(5'b10001), OP_W'(5'b10100), OP_W'(5'b10101), OP_W'(5'b01100),
      OP_W'(5'b01101), OP_W'(5'b01110), OP_W'(5'b01000), OP_W'(5'b00110),
      OP_W'(5'b01001), OP_W'(5'b00101), OP_W'(5'b00100): f_op_legal = 1'b1;
      default:                                           f_op_legal = 1'b0;
    endcase
  endfunction

  assign w_acc_legal = f_op_legal(w_acc_op);
  assign o_resp_err  = r_resp_err;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= 1'b0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= 1'b0;
      r_resp_data  <= '0;
`ifdef ALU_ARB_OPCHECK_EN
      r_resp_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_op <= w_acc_op;
            r_a  <= w_acc_a;
            r_b  <= w_acc_b;
            r_id <= w_acc_id;
`ifdef ALU_ARB_OPCHECK_EN
            // illegal opcode never reaches the ALU; answer with an error right away
            if (!w_acc_legal) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_id    <= w_acc_id;
              r_resp_data  <= '0;
              r_resp_err   <= 1'b1;
            end else begin
              r_state <= S_EXEC;
            end
`else
            r_state <= S_EXEC;
`endif
          end
        end
        S_EXEC: begin
          r_resp_data  <= i_alu_res;
          r_resp_id    <= r_id;
          r_resp_valid <= 1'b1;
`ifdef ALU_ARB_OPCHECK_EN
          r_resp_err   <= 1'b0;
`endif
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_rr_ptr     <= ~r_id;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
